// File: rtl/key_instruct_arb_if.sv
// Signal bundle between the key instruct arbiter and its requesters/consumer.
// The slave modport is the arbiter's view; master is the driving side.
interface key_instruct_arb_if;
  logic        key_lr_status;
  logic        key_instruct_valid;
  logic [15:0] key_instruct;
  logic        host_instruct_valid;
  logic [15:0] host_instruct;
  logic [31:0] cfg_ack_timeout;
  logic        ins_valid;
  logic [15:0] ins_data;
  logic        ins_src;
  logic        ins_ack;
  logic        timeout_pulse;
  logic [15:0] drop_cnt_local;
  logic [15:0] drop_cnt_remote;

  modport master (
    output key_lr_status, key_instruct_valid, key_instruct,
           host_instruct_valid, host_instruct, cfg_ack_timeout, ins_ack,
    input  ins_valid, ins_data, ins_src, timeout_pulse,
           drop_cnt_local, drop_cnt_remote
  );

  modport slave (
    input  key_lr_status, key_instruct_valid, key_instruct,
           host_instruct_valid, host_instruct, cfg_ack_timeout, ins_ack,
    output ins_valid, ins_data, ins_src, timeout_pulse,
           drop_cnt_local, drop_cnt_remote
  );
endinterface

// File: rtl/key_instruct_arb.sv
// Arbitrates local-panel and remote-host key instructs onto one valid/ack consumer,
// with a FIFO per requester, starvation guard, ack timeout and drop statistics.
module key_instruct_arb #(
  parameter int U_DLY      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk_sys,
  input logic               rst_n,
  key_instruct_arb_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
  state_t state_reg, state_next;

  // Requester index 0 = remote host, 1 = local panel, so the index is ins_src.
  logic [1:0]       push_req;
  logic [1:0][15:0] push_word;
  logic [1:0]       fifo_empty;
  logic [1:0]       fifo_full;
  logic [1:0]       pop;
  logic [1:0][15:0] head_word;
  logic [1:0][15:0] drop_cnt;

  assign push_req  = {bus.key_instruct_valid, bus.host_instruct_valid};
  assign push_word = {bus.key_instruct, bus.host_instruct};

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || U_DLY < 0) begin : g_illegal_params
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [15:0] drop_reg;

    assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full[gi]  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                            (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign head_word[gi]  = mem[rd_ptr_reg[AW-1:0]];
    assign drop_cnt[gi]   = drop_reg;

    always_ff @(posedge clk_sys) begin
      if (push_req[gi] && !fifo_full[gi])
        mem[wr_ptr_reg[AW-1:0]] <= push_word[gi];
    end

    // Fullness is the pre-pop value, so a write into a full FIFO drops even on a pop cycle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        drop_reg   <= '0;
      end else begin
        if (push_req[gi]) begin
          if (!fifo_full[gi])
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          else if (drop_reg != 16'hFFFF)
            drop_reg <= drop_reg + 16'd1;
        end
        if (pop[gi])
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  logic        owner;
  logic        owner_has;
  logic        other_has;
  logic        gsel;
  logic        grant;
  logic        tmo_hit;
  logic        lr_changed;
  logic        lr_prev_reg;
  logic [2:0]  starv_reg;
  logic [31:0] timer_reg;
  logic [31:0] tmo_cfg_reg;
  logic        ins_valid_reg;
  logic [15:0] ins_data_reg;
  logic        ins_src_reg;
  logic        timeout_pulse_reg;

  assign owner      = bus.key_lr_status;
  assign owner_has  = !fifo_empty[owner];
  assign other_has  = !fifo_empty[~owner];
  assign gsel       = (owner_has && !(starv_reg == 3'd4 && other_has)) ? owner : ~owner;
  assign lr_changed = (bus.key_lr_status != lr_prev_reg);

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    pop        = '0;
    tmo_hit    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (owner_has || other_has) begin
          grant      = 1'b1;
          pop[gsel]  = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.ins_ack) begin
          state_next = S_GAP;
        end else if (tmo_cfg_reg != 32'd0 && timer_reg == tmo_cfg_reg) begin
          tmo_hit    = 1'b1;
          state_next = S_GAP;
        end
      end
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= S_IDLE;
      ins_valid_reg     <= 1'b0;
      ins_data_reg      <= '0;
      ins_src_reg       <= 1'b0;
      timeout_pulse_reg <= 1'b0;
      timer_reg         <= '0;
      tmo_cfg_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      timeout_pulse_reg <= tmo_hit;
      if (grant) begin
        ins_valid_reg <= 1'b1;
        ins_data_reg  <= head_word[gsel];
        ins_src_reg   <= gsel;
        timer_reg     <= 32'd1;
        tmo_cfg_reg   <= bus.cfg_ack_timeout;
      end else if (state_reg == S_ISSUE) begin
        if (state_next == S_GAP)
          ins_valid_reg <= 1'b0;
        else
          timer_reg <= timer_reg + 32'd1;
      end
    end
  end

  // Counts consecutive owner grants taken while the other side was waiting.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      starv_reg   <= '0;
      lr_prev_reg <= 1'b0;
    end else begin
      lr_prev_reg <= bus.key_lr_status;
      if (lr_changed || !other_has)
        starv_reg <= '0;
      else if (grant)
        starv_reg <= (gsel == owner && starv_reg != 3'd7) ? starv_reg + 3'd1 : 3'd0;
    end
  end

  assign bus.ins_valid       = ins_valid_reg;
  assign bus.ins_data        = ins_data_reg;
  assign bus.ins_src         = ins_src_reg;
  assign bus.timeout_pulse   = timeout_pulse_reg;
  assign bus.drop_cnt_local  = drop_cnt[1];
  assign bus.drop_cnt_remote = drop_cnt[0];
endmodule

// File: tb/tb_key_instruct_arb.sv
// Self-checking bench for key_instruct_arb: constant vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_key_instruct_arb;
  localparam int DEPTH = 4;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  key_instruct_arb_if bus();

  key_instruct_arb #(.U_DLY(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_each = 1'b1;

  // Reference model: per-source queues plus the observable offer state.
  logic [15:0] ql[$];
  logic [15:0] qr[$];
  bit          m_valid, m_src, m_pulse, m_cool, m_prev_lr;
  logic [15:0] m_data, m_drop_l, m_drop_r;
  int unsigned m_age, m_tmo, m_starv;

  logic [16:0] seen[$];
  bit          prev_valid;

  typedef struct {
    bit          lr;
    bit          kv;
    logic [15:0] kw;
    bit          ack;
    bit          e_valid;
    logic [15:0] e_data;
    bit          e_src;
  } vec_t;
  vec_t vt[5];

  logic [16:0] exp_starv[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    ql.delete();
    qr.delete();
    m_valid = 0; m_src = 0; m_pulse = 0; m_cool = 0; m_prev_lr = 0;
    m_data = '0; m_drop_l = '0; m_drop_r = '0;
    m_age = 0; m_tmo = 0; m_starv = 0;
  endfunction

  function automatic void model_step();
    bit lr      = bus.key_lr_status;
    bit l_full  = (ql.size() == DEPTH);
    bit r_full  = (qr.size() == DEPTH);
    bit own_has = lr ? (ql.size() != 0) : (qr.size() != 0);
    bit oth_has = lr ? (qr.size() != 0) : (ql.size() != 0);
    bit granted = 0;
    bit pick    = 0;
    m_pulse = 0;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_valid) begin
      if (bus.ins_ack) begin
        m_valid = 0; m_cool = 1;
      end else if (m_tmo != 0 && m_age == m_tmo) begin
        m_valid = 0; m_cool = 1; m_pulse = 1;
      end else begin
        m_age++;
      end
    end else if (own_has || oth_has) begin
      granted = 1;
      pick    = (own_has && !(m_starv == 4 && oth_has)) ? lr : !lr;
      m_data  = pick ? ql.pop_front() : qr.pop_front();
      m_src   = pick;
      m_valid = 1;
      m_age   = 1;
      m_tmo   = bus.cfg_ack_timeout;
    end
    if (lr != m_prev_lr || !oth_has) m_starv = 0;
    else if (granted) m_starv = (pick == lr) ? m_starv + 1 : 0;
    m_prev_lr = lr;
    if (bus.key_instruct_valid) begin
      if (l_full) begin if (m_drop_l != 16'hFFFF) m_drop_l++; end
      else ql.push_back(bus.key_instruct);
    end
    if (bus.host_instruct_valid) begin
      if (r_full) begin if (m_drop_r != 16'hFFFF) m_drop_r++; end
      else qr.push_back(bus.host_instruct);
    end
  endfunction

  task automatic check_outputs(input string name);
    check(name,
          {bus.ins_valid, bus.ins_data, bus.ins_src, bus.timeout_pulse, bus.drop_cnt_local, bus.drop_cnt_remote},
          {m_valid, m_data, m_src, m_pulse, m_drop_l, m_drop_r});
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (chk_each) check_outputs($sformatf("model_cycle@%0t", $time));
    if (bus.ins_valid && !prev_valid) seen.push_back({bus.ins_src, bus.ins_data});
    prev_valid = bus.ins_valid;
  endtask

  task automatic push(input bit loc, input logic [15:0] w);
    if (loc) begin bus.key_instruct_valid = 1'b1; bus.key_instruct = w; end
    else begin bus.host_instruct_valid = 1'b1; bus.host_instruct = w; end
    tick();
    bus.key_instruct_valid  = 1'b0;
    bus.host_instruct_valid = 1'b0;
  endtask

  task automatic push2(input logic [15:0] lw, input logic [15:0] rw);
    bus.key_instruct_valid  = 1'b1; bus.key_instruct  = lw;
    bus.host_instruct_valid = 1'b1; bus.host_instruct = rw;
    tick();
    bus.key_instruct_valid  = 1'b0;
    bus.host_instruct_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    prev_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    bit fell, pulse_at_fall;
    bus.key_lr_status       = 1'b1;
    bus.key_instruct_valid  = 1'b0;
    bus.key_instruct        = '0;
    bus.host_instruct_valid = 1'b0;
    bus.host_instruct       = '0;
    bus.cfg_ack_timeout     = '0;
    bus.ins_ack             = 1'b0;
    model_reset();
    prev_valid = 1'b0;

    // Reset state
    repeat (2) tick();
    check("reset_outputs",
          {bus.ins_valid, bus.ins_data, bus.ins_src, bus.timeout_pulse, bus.drop_cnt_local, bus.drop_cnt_remote},
          51'd0);
    rst_n = 1'b1;
    tick();

    // Single local strobe, ack tied high: two-cycle latency, one-cycle offer
    vt[0] = '{1'b1, 1'b1, 16'h0012, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 1'b1};
    vt[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b1};
    vt[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b1};
    vt[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 1'b1};
    for (int i = 0; i < 5; i++) begin
      bus.key_lr_status      = vt[i].lr;
      bus.key_instruct_valid = vt[i].kv;
      bus.key_instruct       = vt[i].kw;
      bus.ins_ack            = vt[i].ack;
      tick();
      check($sformatf("vec%0d", i), {bus.ins_valid, bus.ins_data, bus.ins_src},
            {vt[i].e_valid, vt[i].e_data, vt[i].e_src});
    end
    bus.key_instruct_valid = 1'b0;
    check("vec_drops", {bus.drop_cnt_local, bus.drop_cnt_remote}, 32'd0);

    // Six back-to-back local strobes against a stalled consumer
    bus.ins_ack = 1'b0;
    bus.cfg_ack_timeout = 32'd0;
    seen.delete();
    for (int i = 1; i <= 6; i++) push(1'b1, 16'(i));
    tick();
    check("bb_drop_local", bus.drop_cnt_local, 16'd1);
    check("bb_inflight", {bus.ins_valid, bus.ins_data}, {1'b1, 16'h0001});
    bus.ins_ack = 1'b1;
    repeat (20) tick();
    bus.ins_ack = 1'b0;
    check("bb_issued_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      check($sformatf("bb_order%0d", i), seen[i], {1'b1, 16'(i + 1)});

    // Starvation guard: remote owns priority, local slips in after 4 remote grants
    bus.key_lr_status = 1'b0;
    repeat (2) tick();
    seen.delete();
    push2(16'hB001, 16'hA001);
    push2(16'hB002, 16'hA002);
    push(1'b0, 16'hA003);
    push(1'b0, 16'hA004);
    push(1'b0, 16'hA005);
    repeat (3) tick();
    bus.ins_ack = 1'b1;
    repeat (30) tick();
    push(1'b0, 16'hA006);
    repeat (6) tick();
    bus.ins_ack = 1'b0;
    exp_starv = '{17'h0A001, 17'h0A002, 17'h0A003, 17'h0A004,
                  17'h1B001, 17'h0A005, 17'h1B002, 17'h0A006};
    check("starv_issued_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check($sformatf("starv_order%0d", i), seen[i], exp_starv[i]);

    // Ack timeout of 10 cycles, then ack landing on the timeout cycle
    bus.key_lr_status   = 1'b1;
    bus.cfg_ack_timeout = 32'd10;
    push(1'b1, 16'hC001);
    hi = 0; fell = 0; pulse_at_fall = 0;
    for (int c = 0; c < 40 && !fell; c++) begin
      if (c == 0) begin bus.key_instruct_valid = 1'b1; bus.key_instruct = 16'hC002; end
      else bus.key_instruct_valid = 1'b0;
      tick();
      if (bus.ins_valid) hi++;
      else if (hi > 0) begin fell = 1; pulse_at_fall = bus.timeout_pulse; end
    end
    bus.key_instruct_valid = 1'b0;
    check("tmo_high_cycles", hi, 10);
    check("tmo_pulse_at_fall", pulse_at_fall, 1'b1);
    tick();
    check("tmo_gap", {bus.ins_valid, bus.timeout_pulse}, 2'b00);
    tick();
    check("tmo_next_word", {bus.ins_valid, bus.ins_data}, {1'b1, 16'hC002});
    repeat (9) tick();
    check("ack10_still_valid", bus.ins_valid, 1'b1);
    bus.ins_ack = 1'b1;
    tick();
    bus.ins_ack = 1'b0;
    check("ack10_no_pulse", {bus.ins_valid, bus.timeout_pulse}, 2'b00);
    repeat (3) tick();

    // Asynchronous reset in the middle of an offer with 3 entries buffered
    bus.cfg_ack_timeout = 32'd0;
    for (int i = 0; i < 4; i++) push(1'b1, 16'hD001 + 16'(i));
    repeat (2) tick();
    check("pre_rst_valid", bus.ins_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    model_reset();
    prev_valid = 1'b0;
    #1;
    check("async_rst_valid", bus.ins_valid, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus.ins_ack = 1'b1;
    seen.delete();
    repeat (10) tick();
    check("rst_nothing_issued", seen.size(), 0);

    // Randomized traffic against the model
    bus.cfg_ack_timeout = 32'd3;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) bus.key_lr_status = ~bus.key_lr_status;
      bus.key_instruct_valid  = ($urandom_range(0, 2) == 0);
      bus.key_instruct        = 16'($urandom);
      bus.host_instruct_valid = ($urandom_range(0, 2) == 0);
      bus.host_instruct       = 16'($urandom);
      bus.ins_ack             = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) bus.cfg_ack_timeout = 32'($urandom_range(0, 4));
      tick();
    end
    bus.key_instruct_valid  = 1'b0;
    bus.host_instruct_valid = 1'b0;

    // Drop counter saturation on a full, stalled local FIFO
    bus.ins_ack = 1'b0;
    bus.cfg_ack_timeout = 32'd0;
    bus.key_lr_status = 1'b1;
    do_reset();
    chk_each = 1'b0;
    bus.key_instruct_valid = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      bus.key_instruct = 16'(c);
      tick();
    end
    bus.key_instruct_valid = 1'b0;
    chk_each = 1'b1;
    tick();
    check("sat_drop_local", bus.drop_cnt_local, 16'hFFFF);
    check("sat_drop_remote", bus.drop_cnt_remote, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
